// File: rtl/spike_decoder5.sv
// Output decoder for the 5-neuron layer: counts spikes per channel over a fixed
// window, then scans for the strongest channel and holds it under a valid/ack handshake.
module spike_decoder5 #(
  parameter int unsigned WINDOW = 64,
  parameter int unsigned CNT_W  = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [7:0]       in0,
  input  logic [7:0]       in1,
  input  logic [7:0]       in2,
  input  logic [7:0]       in3,
  input  logic [7:0]       in4,
  output logic             busy,
  output logic             result_valid,
  output logic [2:0]       result_class,
  output logic [CNT_W-1:0] result_count,
  input  logic             result_ack
);

  localparam int unsigned WC_W = (WINDOW > 1) ? $clog2(WINDOW) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACCUM,
    S_COMPARE,
    S_DONE
  } state_t;

  state_t           r_state;
  state_t           w_next;

  logic [CNT_W-1:0] r_cnt [5];
  logic [WC_W-1:0]  r_win;
  logic [2:0]       r_idx;
  logic [2:0]       r_best_idx;
  logic [CNT_W-1:0] r_best_cnt;
  logic [2:0]       r_res_class;
  logic [CNT_W-1:0] r_res_count;

  logic [4:0]       w_spike;
  logic             w_win_last;
  logic             w_scan_last;
  logic [CNT_W-1:0] w_cand;
  logic             w_take;
  logic [CNT_W-1:0] w_sel_cnt;
  logic [2:0]       w_sel_idx;

  assign w_spike     = {in4 != '0, in3 != '0, in2 != '0, in1 != '0, in0 != '0};
  assign w_win_last  = (r_win == WC_W'(WINDOW - 1));
  assign w_scan_last = (r_idx == 3'd4);

  // Strict greater-than keeps the earliest channel on ties.
  assign w_cand    = r_cnt[r_idx];
  assign w_take    = (w_cand > r_best_cnt);
  assign w_sel_cnt = w_take ? w_cand : r_best_cnt;
  assign w_sel_idx = w_take ? r_idx  : r_best_idx;

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:    if (start)       w_next = S_ACCUM;
      S_ACCUM:   if (w_win_last)  w_next = S_COMPARE;
      S_COMPARE: if (w_scan_last) w_next = S_DONE;
      S_DONE:    if (result_ack)  w_next = S_IDLE;
      default:                    w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < 5; i++) r_cnt[i] <= '0;
      r_win       <= '0;
      r_idx       <= '0;
      r_best_idx  <= '0;
      r_best_cnt  <= '0;
      r_res_class <= '0;
      r_res_count <= '0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (start) begin
            for (int unsigned i = 0; i < 5; i++) r_cnt[i] <= '0;
            r_win      <= '0;
            r_idx      <= '0;
            r_best_idx <= '0;
            r_best_cnt <= '0;
          end
        end
        S_ACCUM: begin
          for (int unsigned i = 0; i < 5; i++) begin
            if (w_spike[i] && (r_cnt[i] != '1)) r_cnt[i] <= r_cnt[i] + 1'b1;
          end
          r_win <= r_win + 1'b1;
        end
        S_COMPARE: begin
          r_best_cnt <= w_sel_cnt;
          r_best_idx <= w_sel_idx;
          r_idx      <= r_idx + 1'b1;
          // Publish on the final channel so DONE sees a complete result.
          if (w_scan_last) begin
            r_res_count <= w_sel_cnt;
            r_res_class <= (w_sel_cnt == '0) ? 3'd7 : w_sel_idx;
          end
        end
        default: ;
      endcase
    end
  end

  assign busy         = (r_state == S_ACCUM) || (r_state == S_COMPARE);
  assign result_valid = (r_state == S_DONE);
  assign result_class = r_res_class;
  assign result_count = r_res_count;

endmodule
